// File: rtl/door_ctrl_pkg.sv
// Shared types for the multi-channel door controller.
//   door_mode_e  : global mode (AUTO, FORCE_OPEN, FORCE_CLOSED)
//   door_state_e : per-channel door FSM state (CLOSED, OPEN, HOLD)
//   decode_mode  : maps the raw 2-bit mode input, folding 2'b11 into AUTO
package door_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        AUTO         = 2'b00,
        FORCE_OPEN   = 2'b01,
        FORCE_CLOSED = 2'b10
    } door_mode_e;

    typedef enum logic [1:0] {
        CLOSED = 2'b00,
        OPEN   = 2'b01,
        HOLD   = 2'b10
    } door_state_e;

    // The unused encoding 2'b11 behaves exactly like AUTO.
    function automatic door_mode_e decode_mode(input logic [MODE_W-1:0] raw);
        door_mode_e m;
        case (raw)
            2'b01:   m = FORCE_OPEN;
            2'b10:   m = FORCE_CLOSED;
            default: m = AUTO;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/door_channel.sv
// One door channel: mat debouncer, CLOSED/OPEN/HOLD FSM with close delay,
// and the registered rising-edge pulse of the door-open command.
//   clk, rst      : clock, synchronous active-high reset
//   i_mat         : raw mat level (already synchronous)
//   i_mode        : decoded global mode
//   o_door_open   : door open command (state != CLOSED)
//   o_open_pulse  : one-cycle pulse on the first cycle o_door_open is high
module door_channel
    import door_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mat,
    input  door_mode_e i_mode,
    output logic       o_door_open,
    output logic       o_open_pulse
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_CYCLES - 1);

    logic              r_deb;
    logic [DCNT_W-1:0] r_dcnt;
    door_state_e       r_state;
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_pulse;

    door_state_e       w_state_nxt;
    logic [HCNT_W-1:0] w_hcnt_nxt;
    logic              w_pulse_nxt;

    // Debouncer: flip only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb  <= 1'b0;
            r_dcnt <= '0;
        end else if (i_mat != r_deb) begin
            if (r_dcnt == DCNT_LAST) begin
                r_deb  <= i_mat;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + DCNT_W'(1);
            end
        end else begin
            r_dcnt <= '0;
        end
    end

    // FSM state, hold counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLOSED;
            r_hcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // Next-state logic; force modes override, AUTO resumes from current state.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        case (i_mode)
            FORCE_OPEN: begin
                w_state_nxt = OPEN;
            end
            FORCE_CLOSED: begin
                w_state_nxt = CLOSED;
                w_hcnt_nxt  = '0;
            end
            default: begin
                case (r_state)
                    CLOSED: begin
                        if (r_deb) w_state_nxt = OPEN;
                    end
                    OPEN: begin
                        if (!r_deb) begin
                            w_state_nxt = HOLD;
                            w_hcnt_nxt  = HCNT_LOAD;
                        end
                    end
                    HOLD: begin
                        if (r_deb) begin
                            w_state_nxt = OPEN;
                        end else if (r_hcnt == '0) begin
                            w_state_nxt = CLOSED;
                        end else begin
                            w_hcnt_nxt = r_hcnt - HCNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = CLOSED;
                        w_hcnt_nxt  = '0;
                    end
                endcase
            end
        endcase
        // Pulse lands in the same cycle the door first reads open.
        w_pulse_nxt = (r_state == CLOSED) && (w_state_nxt != CLOSED);
    end

    assign o_door_open  = (r_state != CLOSED);
    assign o_open_pulse = r_pulse;

endmodule

// File: rtl/multi_door_controller.sv
// Multi-channel automatic door controller: NUM_DOORS independent channels
// plus a shared saturating count of door-open events.
//   clk, rst      : clock, synchronous active-high reset
//   sensor_mat    : per-door mat levels
//   mode          : 00 AUTO, 01 FORCE_OPEN, 10 FORCE_CLOSED, 11 AUTO
//   clear_count   : synchronous clear of total_opens (beats increment)
//   door_open     : per-door open command
//   open_pulse    : per-door one-cycle open pulse
//   total_opens   : saturating count of open pulses across all doors
module multi_door_controller
    import door_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DOORS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES     = 8,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_DOORS-1:0] sensor_mat,
    input  logic [MODE_W-1:0]    mode,
    input  logic                 clear_count,
    output logic [NUM_DOORS-1:0] door_open,
    output logic [NUM_DOORS-1:0] open_pulse,
    output logic [COUNT_W-1:0]   total_opens
);

    localparam int unsigned PC_W  = $clog2(NUM_DOORS + 1);
    localparam int unsigned SUM_W = ((COUNT_W > PC_W) ? COUNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] SAT_VAL = SUM_W'({COUNT_W{1'b1}});

    door_mode_e            w_mode;
    logic [NUM_DOORS-1:0]  w_door_open;
    logic [NUM_DOORS-1:0]  w_open_pulse;
    logic [PC_W-1:0]       w_pc;
    logic [SUM_W-1:0]      w_sum;
    logic [COUNT_W-1:0]    r_total;

    assign w_mode = decode_mode(mode);

    for (genvar g = 0; g < NUM_DOORS; g++) begin : g_ch
        door_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_mat        (sensor_mat[g]),
            .i_mode       (w_mode),
            .o_door_open  (w_door_open[g]),
            .o_open_pulse (w_open_pulse[g])
        );
    end

    // Number of doors pulsing this cycle.
    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < NUM_DOORS; i++) begin
            w_pc = w_pc + PC_W'(w_open_pulse[i]);
        end
        w_sum = SUM_W'(r_total) + SUM_W'(w_pc);
    end

    // Saturating event counter; a clear drops the same-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            r_total <= '0;
        end else if (w_sum > SAT_VAL) begin
            r_total <= '1;
        end else begin
            r_total <= COUNT_W'(w_sum);
        end
    end

    assign door_open   = w_door_open;
    assign open_pulse  = w_open_pulse;
    assign total_opens = r_total;

endmodule

// File: tb/tb_multi_door_controller.sv
// Bench for multi_door_controller: a cycle reference model pushes the expected
// outputs for every clock edge to a scoreboard queue, a monitor pops and
// compares them after the edge, and directed checks cover the scenarios.
module tb_multi_door_controller;

    localparam int unsigned ND   = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned HLD  = 8;
    localparam int unsigned CW   = 3;
    localparam int          MAXV = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] sensor_mat;
    logic [1:0]    mode;
    logic          clear_count;
    logic [ND-1:0] door_open;
    logic [ND-1:0] open_pulse;
    logic [CW-1:0] total_opens;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [ND-1:0] exp_open;
        logic [ND-1:0] exp_pulse;
        int            exp_total;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: 0 closed, 1 open, 2 hold.
    logic          m_deb[ND];
    int            m_run[ND];
    int            m_st[ND];
    int            m_hold[ND];
    logic [ND-1:0] m_pulse;
    int            m_total;

    multi_door_controller #(
        .NUM_DOORS       (ND),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .COUNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_mat  (sensor_mat),
        .mode        (mode),
        .clear_count (clear_count),
        .door_open   (door_open),
        .open_pulse  (open_pulse),
        .total_opens (total_opens)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        logic [ND-1:0] np;
        int            ns;
        int            sum;
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                m_deb[i] = 1'b0; m_run[i] = 0; m_st[i] = 0; m_hold[i] = 0;
            end
            m_pulse = '0;
            m_total = 0;
            return;
        end
        sum = m_total + $countones(m_pulse);
        if (clear_count)     m_total = 0;
        else if (sum > MAXV) m_total = MAXV;
        else                 m_total = sum;
        np = '0;
        for (int i = 0; i < ND; i++) begin
            ns = m_st[i];
            if (mode == 2'b01) begin
                ns = 1;
            end else if (mode == 2'b10) begin
                ns = 0;
                m_hold[i] = 0;
            end else if (m_st[i] == 0) begin
                if (m_deb[i]) ns = 1;
            end else if (m_st[i] == 1) begin
                if (!m_deb[i]) begin ns = 2; m_hold[i] = HLD - 1; end
            end else begin
                if (m_deb[i])            ns = 1;
                else if (m_hold[i] == 0) ns = 0;
                else                     m_hold[i]--;
            end
            np[i] = (m_st[i] == 0) && (ns != 0);
            m_st[i] = ns;
            if (sensor_mat[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = sensor_mat[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pulse = np;
    endtask

    // Push the expectation for the coming edge, then move to the next falling edge.
    task automatic tick();
        exp_t e;
        logic [ND-1:0] op;
        model_step();
        for (int i = 0; i < ND; i++) op[i] = (m_st[i] != 0);
        e.exp_open  = op;
        e.exp_pulse = m_pulse;
        e.exp_total = m_total;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Scoreboard monitor: compare one expectation per edge.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb_door_open", 32'(door_open), 32'(e.exp_open));
            check_eq("sb_open_pulse", 32'(open_pulse), 32'(e.exp_pulse));
            check_eq("sb_total_opens", 32'(total_opens), 32'(e.exp_total));
        end
    end

    initial begin
        rst = 1'b1; sensor_mat = '0; mode = 2'b00; clear_count = 1'b0;
        @(negedge clk);
        ticks(3);
        check_eq("rst_door_open", 32'(door_open), 32'h0);
        check_eq("rst_open_pulse", 32'(open_pulse), 32'h0);
        check_eq("rst_total", 32'(total_opens), 32'h0);
        rst = 1'b0;

        // Basic open/close on door 0: mat high for edges 10..29.
        for (int n = 1; n <= 45; n++) begin
            sensor_mat[0] = (n >= 10 && n < 30);
            tick();
            check_eq($sformatf("basic_open_e%0d", n), 32'(door_open[0]), 32'((n >= 13 && n <= 40) ? 1 : 0));
            check_eq($sformatf("basic_pulse_e%0d", n), 32'(open_pulse[0]), 32'((n == 13) ? 1 : 0));
        end
        check_eq("basic_total", 32'(total_opens), 32'd1);

        // Two-cycle glitch on door 1 must be ignored.
        for (int n = 0; n < 10; n++) begin
            sensor_mat[1] = (n < 2);
            tick();
            check_eq("glitch_open", 32'(door_open[1]), 32'h0);
        end
        check_eq("glitch_total", 32'(total_opens), 32'd1);

        // Retrigger on door 2 during HOLD.
        sensor_mat[2] = 1'b1;
        ticks(20);
        check_eq("retrig_opened", 32'(door_open[2]), 32'h1);
        for (int n = 0; n < 16; n++) begin
            sensor_mat[2] = (n >= 6);
            tick();
            check_eq("retrig_stay_open", 32'(door_open[2]), 32'h1);
            check_eq("retrig_no_pulse", 32'(open_pulse[2]), 32'h0);
        end
        sensor_mat[2] = 1'b0;
        ticks(15);
        check_eq("retrig_closed", 32'(door_open[2]), 32'h0);
        check_eq("retrig_total", 32'(total_opens), 32'd2);

        // Force modes.
        mode = 2'b01;
        tick();
        check_eq("fopen_all", 32'(door_open), 32'hF);
        tick();
        check_eq("fopen_total", 32'(total_opens), 32'd6);
        sensor_mat = 4'hF; mode = 2'b10;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_eq("fclose_all", 32'(door_open), 32'h0);
        end
        mode = 2'b00;
        tick();
        check_eq("auto_reopen", 32'(door_open), 32'hF);
        check_eq("auto_reopen_pulse", 32'(open_pulse), 32'hF);
        tick();
        check_eq("auto_sat_total", 32'(total_opens), 32'd7);
        sensor_mat = '0;
        ticks(15);
        check_eq("auto_all_closed", 32'(door_open), 32'h0);

        // Counter: clear, count, saturate, clear beating a pulse.
        clear_count = 1'b1;
        tick();
        check_eq("clear_total", 32'(total_opens), 32'd0);
        clear_count = 1'b0;
        mode = 2'b01; tick();
        mode = 2'b10; tick();
        check_eq("cnt_four", 32'(total_opens), 32'd4);
        mode = 2'b01; tick();
        mode = 2'b10; tick();
        mode = 2'b00; sensor_mat[0] = 1'b1;
        ticks(5);
        check_eq("cnt_ninth_open", 32'(door_open[0]), 32'h1);
        check_eq("cnt_saturated", 32'(total_opens), 32'd7);
        sensor_mat = '0;
        ticks(15);
        mode = 2'b01;
        tick();
        check_eq("clr_pulse_present", 32'(open_pulse), 32'hF);
        clear_count = 1'b1;
        tick();
        check_eq("clr_wins", 32'(total_opens), 32'd0);
        clear_count = 1'b0;
        tick();
        check_eq("clr_pulses_lost", 32'(total_opens), 32'd0);

        // Reset during HOLD, then a fresh debounce on door 3.
        mode = 2'b00;
        ticks(3);
        check_eq("hold_before_rst", 32'(door_open), 32'hF);
        rst = 1'b1; sensor_mat = 4'b1000;
        tick();
        check_eq("midrst_open", 32'(door_open), 32'h0);
        check_eq("midrst_pulse", 32'(open_pulse), 32'h0);
        check_eq("midrst_total", 32'(total_opens), 32'h0);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            check_eq($sformatf("post_rst_e%0d", n), 32'(door_open), 32'((n >= 4) ? 8 : 0));
        end

        // Mode 2'b11 behaves like AUTO: door 3 holds then closes.
        mode = 2'b11; sensor_mat = '0;
        ticks(10);
        check_eq("mode11_holding", 32'(door_open[3]), 32'h1);
        ticks(3);
        check_eq("mode11_closed", 32'(door_open[3]), 32'h0);

        ticks(2);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_door_controller.md
# multi_door_controller

Parametrised multi-channel automatic door controller. It is the successor to the single-mat, edge-triggered door controller. Each channel debounces its own pressure-mat input and tracks the door through a CLOSED/OPEN/HOLD state machine with a programmable close delay. A global mode input can force all doors open or closed. A shared saturating counter records total door-open events for the building-management interface.

## Interface
- NUM_DOORS, 4, number of independent door channels (≥1)
- DEBOUNCE_CYCLES, 3, consecutive cycles a mat input must differ from its debounced value before the debounced value flips (≥1)
- HOLD_CYCLES, 8, cycles a door stays open after its debounced mat goes low (≥1)
- COUNT_W, 16, width of the open-event counter

Ports:
- clk  input  1  single clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- sensor_mat  input  NUM_DOORS  per-door mat level; already synchronous to clk
- mode  input  2  00 AUTO, 01 FORCE_OPEN, 10 FORCE_CLOSED, 11 treated as AUTO
- clear_count  input  1  synchronous clear of total_opens
- door_open  output  NUM_DOORS  per-door open command
- open_pulse  output  NUM_DOORS  one-cycle pulse on each door's 0→1 transition of door_open
- total_opens  output  COUNT_W  saturating count of open events, all channels

## Operation
- Debounce, per channel: register deb and counter dcnt, width $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle, if sensor_mat≠deb: when dcnt==DEBOUNCE_CYCLES-1, set deb←sensor_mat and dcnt←0; otherwise dcnt increments.
  - If sensor_mat==deb: dcnt←0.
  - Debounce runs in every mode.
- FSM, per channel. States are CLOSED, OPEN and HOLD. Hold counter hcnt has width $clog2(HOLD_CYCLES+1).
  - AUTO, CLOSED: deb=1 → OPEN.
  - AUTO, OPEN: deb=0 → HOLD, with hcnt←HOLD_CYCLES-1.
  - AUTO, HOLD: deb=1 → OPEN (retrigger). Else if hcnt==0 → CLOSED. Else hcnt decrements.
  - FORCE_OPEN: next state OPEN, regardless of deb.
  - FORCE_CLOSED: next state CLOSED and hcnt←0, regardless of deb.
  - Leaving a force mode resumes AUTO transitions from the current state. Example: FORCE_OPEN→AUTO with deb=0 gives OPEN→HOLD→CLOSED after HOLD_CYCLES.
- door_open[i] = (state≠CLOSED), decoded from the state register only.
- open_pulse[i] is registered. It is high exactly in the first cycle door_open[i] reads 1 after reading 0.
- total_opens adds popcount(open_pulse) at each edge and saturates at 2^COUNT_W-1.
  - clear_count sets it to 0.
  - clear_count wins over a simultaneous increment; that cycle's pulses are lost.
- mode is sampled every cycle with no internal register. A mode change acts at the next edge.

## Timing
- Reset, synchronous and dominant over all inputs: state CLOSED, deb 0, dcnt 0, hcnt 0, door_open 0, open_pulse 0, total_opens 0.
- Open latency: mat rises, then stays high, from the cycle sampled at edge k. deb sets at edge k+DEBOUNCE_CYCLES-1. door_open rises after edge k+DEBOUNCE_CYCLES.
- Close latency: mat falls, then stays low, at edge k. State enters HOLD at edge k+DEBOUNCE_CYCLES. door_open falls after edge k+DEBOUNCE_CYCLES+HOLD_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles are fully rejected, with no effect on door_open.
- Mode latency is one edge to door_open.
- total_opens reflects a pulse one cycle after open_pulse.
- Reset mid-hold or mid-debounce discards the progress. After release, the door stays closed until a full debounce completes.
- All channels are independent. Several channels may pulse in the same cycle and all are counted.

## Structure
- Package door_ctrl_pkg holds:
  - door_mode_e: AUTO, FORCE_OPEN, FORCE_CLOSED.
  - door_state_e: CLOSED, OPEN, HOLD.
- Sub-module door_channel holds one debouncer, the FSM, hcnt, and the open_pulse register. It is instantiated NUM_DOORS times with a generate loop.
- The top level holds only the popcount and the saturating counter.

## Test plan
Defaults: DEBOUNCE_CYCLES=3, HOLD_CYCLES=8.
- **Basic open/close.** sensor_mat[0] rises at edge 10 and is held until edge 30 → door_open[0] high after edge 13, low after edge 41. open_pulse[0] is high for one cycle only. total_opens=1.
- **Glitch rejection.** sensor_mat[1] high for 2 cycles → door_open[1] stays 0. total_opens is unchanged.
- **Retrigger.** The mat returns high during HOLD for ≥3 cycles → state goes back to OPEN. door_open never drops and there is no second open_pulse.
- **Force modes.** Under FORCE_OPEN, all four door_open bits go high one edge after the mode change, and total_opens +4. Under FORCE_CLOSED, all doors are low one edge later while mats are held high. Back in AUTO with mats high, the doors reopen at the next edge.
- **Counter.** With COUNT_W=3, 9 open events → saturates at 7. clear_count asserted together with a pulse → 0.
- **Reset mid-operation.** rst asserted during HOLD → all outputs 0 next edge. After release with the mat held high, door_open returns after 3 edges of debounce plus 1.
